// File: rtl/flash_rd_pkg.sv
// rtl/flash_rd_pkg.sv - shared types, widths and byte-lane helper for the flash byte reader
//
// Purpose: state encoding, address widths and the little-endian byte-lane
//          select used by both the reader FSM and its bench.
// Contents: FLASH_WORD_AW, BYTE_AW, TAG_W, rd_state_e, byte_lane().
package flash_rd_pkg;

  localparam int FLASH_WORD_AW = 23;
  localparam int BYTE_AW       = 21;
  localparam int TAG_W         = BYTE_AW - 2;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    DONE,
    RELEASE
  } rd_state_e;

  // Little-endian lane pick: lane 0 is the least significant byte.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/flash_byte_reader_if.sv
// rtl/flash_byte_reader_if.sv - single-beat Avalon-MM read bus towards the flash controller
//
// Purpose: bundles the flash read port so the reader and its environment
//          connect through one port.
// Signals: flash_mem_read/address/byteenable/burstcount (master -> slave),
//          flash_mem_waitrequest/readdata/readdatavalid (slave -> master).
interface flash_byte_reader_if;
  import flash_rd_pkg::*;

  logic                     flash_mem_read;
  logic [FLASH_WORD_AW-1:0] flash_mem_address;
  logic [3:0]               flash_mem_byteenable;
  logic [5:0]               flash_mem_burstcount;
  logic                     flash_mem_waitrequest;
  logic [31:0]              flash_mem_readdata;
  logic                     flash_mem_readdatavalid;

  modport master (
    output flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );

endinterface

// File: rtl/flash_word_cache.sv
// rtl/flash_word_cache.sv - one-word read cache holding the last flash word fetched
//
// Purpose: remembers one 32-bit flash word and its word address so the
//          partner byte of a pair can be served without a flash access.
// Ports:   clk, reset_all (sync, active low)
//          fill_i/fill_tag_i/fill_data_i : load a new word and mark valid
//          inval_i                       : drop the cached word (beats a fill)
//          lookup_tag_i -> hit_o, word_o : hit compare and cached word
module flash_word_cache
  import flash_rd_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_all,
  input  logic             fill_i,
  input  logic [TAG_W-1:0] fill_tag_i,
  input  logic [31:0]      fill_data_i,
  input  logic             inval_i,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_o,
  output logic [31:0]      word_o
);

  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      data_q;

  always_ff @(posedge clk) begin
    if (!reset_all) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (fill_i) begin
        tag_q  <= fill_tag_i;
        data_q <= fill_data_i;
      end
      if (inval_i) begin
        valid_q <= 1'b0;
      end else if (fill_i) begin
        valid_q <= 1'b1;
      end
    end
  end

  assign hit_o  = CACHE_EN && valid_q && (tag_q == lookup_tag_i);
  assign word_o = data_q;

endmodule

// File: rtl/flash_byte_reader.sv
// rtl/flash_byte_reader.sv - byte read requests to single-beat 32-bit flash reads
//
// Purpose: turns a held read_start level plus byte address into one Avalon
//          read of the containing word (or a cache hit), returns the byte on
//          data_out and pulses finish_read once.
// Ports:   clk, reset_all (sync, active low)
//          read_start, addr_in, restart_read : request side
//          finish_read, data_out, timeout_err: completion side
//          flash                             : Avalon master towards flash
module flash_byte_reader
  import flash_rd_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1,
  parameter int TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               reset_all,
  input  logic               read_start,
  input  logic [BYTE_AW-1:0] addr_in,
  input  logic               restart_read,
  output logic               finish_read,
  output logic [7:0]         data_out,
  output logic               timeout_err,
  flash_byte_reader_if.master flash
);

  // The read is re-issued after TIMEOUT cycles in WAIT_DATA (count 0..TIMEOUT-1).
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
  localparam logic [9:0] TMO_MAX  = 10'(TIMEOUT);

  rd_state_e          state_q;
  logic [BYTE_AW-1:0] addr_q;
  logic [9:0]         tmo_cnt_q;
  logic [7:0]         data_q;
  logic               tmo_err_q;

  logic               cache_hit;
  logic [31:0]        cache_word;
  logic               fill;

  assign fill = (state_q == WAIT_DATA) && flash.flash_mem_readdatavalid;

  flash_word_cache #(
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk          (clk),
    .reset_all    (reset_all),
    .fill_i       (fill),
    .fill_tag_i   (addr_q[BYTE_AW-1:2]),
    .fill_data_i  (flash.flash_mem_readdata),
    .inval_i      (restart_read),
    .lookup_tag_i (addr_in[BYTE_AW-1:2]),
    .hit_o        (cache_hit),
    .word_o       (cache_word)
  );

  always_ff @(posedge clk) begin
    if (!reset_all) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tmo_cnt_q <= '0;
      data_q    <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (read_start) begin
            addr_q <= addr_in;
            // A restart in the same cycle must not be served from stale data.
            if (cache_hit && !restart_read) begin
              data_q  <= byte_lane(cache_word, addr_in[1:0]);
              state_q <= DONE;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (!flash.flash_mem_waitrequest) begin
            tmo_cnt_q <= '0;
            state_q   <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_q <= tmo_cnt_q + 10'd1;
          end
          // Data arriving on the last allowed cycle still counts as in time.
          if (flash.flash_mem_readdatavalid) begin
            data_q  <= byte_lane(flash.flash_mem_readdata, addr_q[1:0]);
            state_q <= DONE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_err_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        DONE: begin
          state_q <= RELEASE;
        end
        RELEASE: begin
          if (!read_start) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign finish_read = (state_q == DONE);
  assign data_out    = data_q;
  assign timeout_err = tmo_err_q;

  assign flash.flash_mem_read       = (state_q == REQ);
  assign flash.flash_mem_address    = {4'b0, addr_q[BYTE_AW-1:2]};
  assign flash.flash_mem_byteenable = 4'b1111;
  assign flash.flash_mem_burstcount = 6'd1;

endmodule

// File: tb/tb_flash_byte_reader.sv
// tb/tb_flash_byte_reader.sv - directed vector bench for flash_byte_reader
module tb_flash_byte_reader;
  import flash_rd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_all;
  logic        read_start;
  logic [20:0] addr_in;
  logic        restart_read;
  logic        finish_read;
  logic [7:0]  data_out;
  logic        timeout_err;

  flash_byte_reader_if fbus ();

  flash_byte_reader #(
    .CACHE_EN (1'b1),
    .TIMEOUT  (8)
  ) dut (
    .clk          (clk),
    .reset_all    (reset_all),
    .read_start   (read_start),
    .addr_in      (addr_in),
    .restart_read (restart_read),
    .finish_read  (finish_read),
    .data_out     (data_out),
    .timeout_err  (timeout_err),
    .flash        (fbus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] addr;
    bit          rst;
    logic [31:0] word;
    int          wait_n;
    int          dly;
    int          exp_acc;
    int          exp_rdcyc;
    logic [22:0] exp_addr;
    logic [7:0]  exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  int checks   = 0;
  int failures = 0;

  int          r_lat;
  logic [7:0]  r_data;
  int          r_acc;
  int          r_rdcyc;
  int          r_addr_bad;
  int          r_rise2_c;
  int          r_err_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and acts as the flash slave. Cycle c=1 is the cycle
  // right after the edge that samples read_start. The first ignore_n
  // accepted reads never get data back.
  task automatic run_req(input logic [20:0] a, input bit rst, input logic [31:0] w,
                         input int wait_n, input int dly, input int ignore_n,
                         input logic [22:0] exp_addr);
    int  wleft;
    int  pending;
    int  rise;
    bit  prev_rd;
    read_start = 1'b0;
    cyc();
    restart_read = rst;
    cyc();
    restart_read = 1'b0;
    read_start   = 1'b1;
    addr_in      = a;
    r_lat = -1; r_data = '0; r_acc = 0; r_rdcyc = 0; r_addr_bad = 0;
    r_rise2_c = -1; r_err_c = -1;
    wleft = wait_n; pending = -1; rise = 0; prev_rd = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      cyc();
      fbus.flash_mem_readdatavalid = 1'b0;
      fbus.flash_mem_waitrequest   = 1'b0;
      if (timeout_err && r_err_c < 0) r_err_c = c;
      if (fbus.flash_mem_read) begin
        r_rdcyc++;
        if (fbus.flash_mem_address !== exp_addr) r_addr_bad++;
        if (!prev_rd) begin
          rise++;
          if (rise == 2) r_rise2_c = c;
        end
        if (wleft > 0) begin
          fbus.flash_mem_waitrequest = 1'b1;
          wleft--;
        end else begin
          r_acc++;
          if (r_acc > ignore_n) pending = c + dly;
        end
      end
      prev_rd = fbus.flash_mem_read;
      if (c == pending) begin
        fbus.flash_mem_readdatavalid = 1'b1;
        fbus.flash_mem_readdata      = w;
      end
      if (finish_read) begin
        r_lat      = c;
        r_data     = data_out;
        read_start = 1'b0;
        break;
      end
    end
    fbus.flash_mem_readdatavalid = 1'b0;
    fbus.flash_mem_waitrequest   = 1'b0;
    read_start = 1'b0;
  endtask

  initial begin
    int found;
    int fin_cnt;
    int bad;

    vecs[0] = '{21'h000004, 1'b0, 32'h44332211, 0, 2, 1, 1, 23'h000001, 8'h11, 4};
    vecs[1] = '{21'h000005, 1'b0, 32'h44332211, 0, 1, 0, 0, 23'h000001, 8'h22, 1};
    vecs[2] = '{21'h000007, 1'b0, 32'h44332211, 0, 1, 0, 0, 23'h000001, 8'h44, 1};
    vecs[3] = '{21'h000006, 1'b1, 32'h44332211, 0, 1, 1, 1, 23'h000001, 8'h33, 3};
    vecs[4] = '{21'h000102, 1'b0, 32'hDEADBEEF, 5, 2, 1, 6, 23'h000040, 8'hAD, 9};
    vecs[5] = '{21'h000103, 1'b0, 32'hDEADBEEF, 0, 1, 0, 0, 23'h000040, 8'hDE, 1};
    vecs[6] = '{21'h1FFFFD, 1'b0, 32'hA1B2C3D4, 1, 1, 1, 2, 23'h07FFFF, 8'hC3, 4};
    vecs[7] = '{21'h1FFFFC, 1'b0, 32'hA1B2C3D4, 0, 1, 0, 0, 23'h07FFFF, 8'hD4, 1};
    vecs[8] = '{21'h000004, 1'b0, 32'h55667788, 0, 1, 1, 1, 23'h000001, 8'h88, 3};
    vecs[9] = '{21'h000300, 1'b0, 32'h11223344, 0, 1, 1, 1, 23'h0000C0, 8'h44, 3};

    reset_all    = 1'b0;
    read_start   = 1'b0;
    addr_in      = '0;
    restart_read = 1'b0;
    fbus.flash_mem_waitrequest   = 1'b0;
    fbus.flash_mem_readdata      = '0;
    fbus.flash_mem_readdatavalid = 1'b0;
    repeat (3) cyc();
    chk("rst_finish", 32'(finish_read), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_tmo_err", 32'(timeout_err), 32'd0);
    chk("rst_read", 32'(fbus.flash_mem_read), 32'd0);
    chk("rst_addr", 32'(fbus.flash_mem_address), 32'd0);
    chk("const_be", 32'(fbus.flash_mem_byteenable), 32'hF);
    chk("const_burst", 32'(fbus.flash_mem_burstcount), 32'd1);
    reset_all = 1'b1;

    // Timeout: first accepted read never answered, retry answered.
    run_req(21'h000208, 1'b0, 32'h0A0B0C0D, 0, 1, 1, 23'h000082);
    chk("tmo_reissue_cycle", 32'(r_rise2_c), 32'd10);
    chk("tmo_err_first_cycle", 32'(r_err_c), 32'd10);
    chk("tmo_accepts", 32'(r_acc), 32'd2);
    chk("tmo_latency", 32'(r_lat), 32'd12);
    chk("tmo_data", 32'(r_data), 32'h0D);
    cyc();
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].addr, vecs[i].rst, vecs[i].word, vecs[i].wait_n, vecs[i].dly, 0,
              vecs[i].exp_addr);
      chk($sformatf("v%0d_latency", i), 32'(r_lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_data", i), 32'(r_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_accepts", i), 32'(r_acc), 32'(vecs[i].exp_acc));
      chk($sformatf("v%0d_read_cycles", i), 32'(r_rdcyc), 32'(vecs[i].exp_rdcyc));
      chk($sformatf("v%0d_addr_stable", i), 32'(r_addr_bad), 32'd0);
      cyc();
      chk($sformatf("v%0d_single_pulse", i), 32'(finish_read), 32'd0);
      chk($sformatf("v%0d_data_held", i), 32'(data_out), 32'(vecs[i].exp_data));
    end

    // Reset while a miss waits for data; late readdatavalid must be dropped.
    cyc();
    cyc();
    read_start = 1'b1;
    addr_in    = 21'h000400;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (fbus.flash_mem_read) begin
        fbus.flash_mem_waitrequest = 1'b0;
        found = 1;
        break;
      end
    end
    chk("rstmiss_read_seen", 32'(found), 32'd1);
    cyc();
    reset_all  = 1'b0;
    read_start = 1'b0;
    cyc();
    reset_all = 1'b1;
    fbus.flash_mem_readdatavalid = 1'b1;
    fbus.flash_mem_readdata      = 32'h99887766;
    fin_cnt = 0;
    bad     = 0;
    for (int c = 0; c < 6; c++) begin
      if (finish_read) fin_cnt++;
      if (data_out !== 8'h00 || timeout_err !== 1'b0 || fbus.flash_mem_read !== 1'b0 ||
          fbus.flash_mem_address !== 23'h0) bad++;
      cyc();
      fbus.flash_mem_readdatavalid = 1'b0;
    end
    chk("rstmiss_no_finish", 32'(fin_cnt), 32'd0);
    chk("rstmiss_outputs_zero", 32'(bad), 32'd0);

    // 0x000301 shares the word filled by vector 9; reset must have emptied the cache.
    run_req(21'h000301, 1'b0, 32'h11223344, 0, 1, 0, 23'h0000C0);
    chk("post_rst_miss_accepts", 32'(r_acc), 32'd1);
    chk("post_rst_miss_latency", 32'(r_lat), 32'd3);
    chk("post_rst_miss_data", 32'(r_data), 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
